// File: rtl/rs_age_station.sv
// Age-ordered reservation station: holds renamed ALU ops until both operands
// resolve via the broadcast buses, then issues the oldest ready entry.
module rs_age_station #(
    parameter int DEPTH  = 16,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int CDB_N  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [ROB_W-1:0]          in_rob,
    input  logic [DATA_W-1:0]         in_val1,
    input  logic [DATA_W-1:0]         in_val2,
    input  logic [ROB_W-1:0]          in_tag1,
    input  logic [ROB_W-1:0]          in_tag2,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]   cdb_value,
    input  logic                      alu_ready,
    input  logic                      flush,
    output logic [OP_W-1:0]           out_op,
    output logic [DATA_W-1:0]         out_val1,
    output logic [DATA_W-1:0]         out_val2,
    output logic [DATA_W-1:0]         out_imm,
    output logic [ROB_W-1:0]          out_rob,
    output logic [DATA_W-1:0]         out_pc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Result is {hit, value}; the lowest-numbered matching bus wins, tag 0 never matches.
    function automatic logic [DATA_W:0] cdb_match(
        input logic [ROB_W-1:0]        tag,
        input logic [CDB_N-1:0]        bus_valid,
        input logic [CDB_N*ROB_W-1:0]  bus_tag,
        input logic [CDB_N*DATA_W-1:0] bus_value
    );
        logic [DATA_W:0] res;
        res = {(DATA_W+1){1'b0}};
        for (int k = CDB_N - 1; k >= 0; k--) begin
            res = (tag != {ROB_W{1'b0}} && bus_valid[k] && bus_tag[k*ROB_W +: ROB_W] == tag)
                  ? {1'b1, bus_value[k*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    logic [DEPTH-1:0]  busy_r;
    logic [OP_W-1:0]   op_r   [DEPTH];
    logic [ROB_W-1:0]  rob_r  [DEPTH];
    logic [DATA_W-1:0] val1_r [DEPTH];
    logic [DATA_W-1:0] val2_r [DEPTH];
    logic [ROB_W-1:0]  tag1_r [DEPTH];
    logic [ROB_W-1:0]  tag2_r [DEPTH];
    logic [DATA_W-1:0] imm_r  [DEPTH];
    logic [DATA_W-1:0] pc_r   [DEPTH];
    logic [IDX_W-1:0]  age_r  [DEPTH];

    logic [CNT_W-1:0]  count_r;
    logic [OP_W-1:0]   out_op_r;
    logic [DATA_W-1:0] out_val1_r;
    logic [DATA_W-1:0] out_val2_r;
    logic [DATA_W-1:0] out_imm_r;
    logic [ROB_W-1:0]  out_rob_r;
    logic [DATA_W-1:0] out_pc_r;

    logic [DEPTH-1:0]  ready_s;
    logic              found_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [IDX_W-1:0]  best_age_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic              cand_s;
    logic              alloc_s;
    logic              issue_s;
    logic [DATA_W:0]   wake1_s [DEPTH];
    logic [DATA_W:0]   wake2_s [DEPTH];
    logic [DATA_W:0]   byp1_s;
    logic [DATA_W:0]   byp2_s;

    assign in_ready = (count_r < DEPTH_C);
    assign alloc_s  = rdy && in_valid && in_ready && (in_op != {OP_W{1'b0}})
                      && (in_rob != {ROB_W{1'b0}}) && !flush;
    assign issue_s  = rdy && !flush && alu_ready && found_s;

    assign count    = count_r;
    assign out_op   = out_op_r;
    assign out_val1 = out_val1_r;
    assign out_val2 = out_val2_r;
    assign out_imm  = out_imm_r;
    assign out_rob  = out_rob_r;
    assign out_pc   = out_pc_r;

    // Readiness from registered tags, oldest-ready select and lowest free slot.
    always_comb begin
        ready_s    = {DEPTH{1'b0}};
        found_s    = 1'b0;
        pick_idx_s = {IDX_W{1'b0}};
        best_age_s = {IDX_W{1'b0}};
        free_idx_s = {IDX_W{1'b0}};
        cand_s     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = busy_r[i] && (tag1_r[i] == {ROB_W{1'b0}}) && (tag2_r[i] == {ROB_W{1'b0}});
            cand_s     = ready_s[i] && (!found_s || (age_r[i] > best_age_s));
            pick_idx_s = cand_s ? IDX_W'(i) : pick_idx_s;
            best_age_s = cand_s ? age_r[i] : best_age_s;
            found_s    = found_s || cand_s;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = !busy_r[i] ? IDX_W'(i) : free_idx_s;
        end
    end

    // Broadcast-bus matches for stored operands and for the dispatching op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1_s[i] = cdb_match(tag1_r[i], cdb_valid, cdb_tag, cdb_value);
            wake2_s[i] = cdb_match(tag2_r[i], cdb_valid, cdb_tag, cdb_value);
        end
        byp1_s = cdb_match(in_tag1, cdb_valid, cdb_tag, cdb_value);
        byp2_s = cdb_match(in_tag2, cdb_valid, cdb_tag, cdb_value);
    end

    // Entry storage: allocate with bypass, wakeup, ageing, release on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]   <= {OP_W{1'b0}};
                rob_r[i]  <= {ROB_W{1'b0}};
                val1_r[i] <= {DATA_W{1'b0}};
                val2_r[i] <= {DATA_W{1'b0}};
                tag1_r[i] <= {ROB_W{1'b0}};
                tag2_r[i] <= {ROB_W{1'b0}};
                imm_r[i]  <= {DATA_W{1'b0}};
                pc_r[i]   <= {DATA_W{1'b0}};
                age_r[i]  <= {IDX_W{1'b0}};
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    busy_r[i] <= 1'b0;
                end else if (alloc_s && (free_idx_s == IDX_W'(i))) begin
                    busy_r[i] <= 1'b1;
                    op_r[i]   <= in_op;
                    rob_r[i]  <= in_rob;
                    imm_r[i]  <= in_imm;
                    pc_r[i]   <= in_pc;
                    age_r[i]  <= {IDX_W{1'b0}};
                    val1_r[i] <= byp1_s[DATA_W] ? byp1_s[DATA_W-1:0] : in_val1;
                    tag1_r[i] <= byp1_s[DATA_W] ? {ROB_W{1'b0}} : in_tag1;
                    val2_r[i] <= byp2_s[DATA_W] ? byp2_s[DATA_W-1:0] : in_val2;
                    tag2_r[i] <= byp2_s[DATA_W] ? {ROB_W{1'b0}} : in_tag2;
                end else if (busy_r[i]) begin
                    if (wake1_s[i][DATA_W]) begin
                        val1_r[i] <= wake1_s[i][DATA_W-1:0];
                        tag1_r[i] <= {ROB_W{1'b0}};
                    end
                    if (wake2_s[i][DATA_W]) begin
                        val2_r[i] <= wake2_s[i][DATA_W-1:0];
                        tag2_r[i] <= {ROB_W{1'b0}};
                    end
                    if (alloc_s) begin
                        age_r[i] <= age_r[i] + IDX_W'(1);
                    end
                    if (issue_s && (pick_idx_s == IDX_W'(i))) begin
                        busy_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy counter and registered issue port.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= {CNT_W{1'b0}};
            out_op_r   <= {OP_W{1'b0}};
            out_val1_r <= {DATA_W{1'b0}};
            out_val2_r <= {DATA_W{1'b0}};
            out_imm_r  <= {DATA_W{1'b0}};
            out_rob_r  <= {ROB_W{1'b0}};
            out_pc_r   <= {DATA_W{1'b0}};
        end else if (rdy) begin
            if (flush) begin
                count_r  <= {CNT_W{1'b0}};
                out_op_r <= {OP_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, alloc_s} - {{(CNT_W-1){1'b0}}, issue_s};
                if (issue_s) begin
                    out_op_r   <= op_r[pick_idx_s];
                    out_val1_r <= val1_r[pick_idx_s];
                    out_val2_r <= val2_r[pick_idx_s];
                    out_imm_r  <= imm_r[pick_idx_s];
                    out_rob_r  <= rob_r[pick_idx_s];
                    out_pc_r   <= pc_r[pick_idx_s];
                end else begin
                    out_op_r <= {OP_W{1'b0}};
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_age_station.sv
// Scoreboard bench for rs_age_station: expected issues are queued at dispatch
// and compared field by field when the station issues them.
module tb_rs_age_station;

    localparam int DEPTH  = 16;
    localparam int ROB_W  = 4;
    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int CDB_N  = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rdy;
    logic                    in_valid;
    logic                    in_ready;
    logic [OP_W-1:0]         in_op;
    logic [ROB_W-1:0]        in_rob;
    logic [DATA_W-1:0]       in_val1, in_val2, in_imm, in_pc;
    logic [ROB_W-1:0]        in_tag1, in_tag2;
    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*ROB_W-1:0]  cdb_tag;
    logic [CDB_N*DATA_W-1:0] cdb_value;
    logic                    alu_ready;
    logic                    flush;
    logic [OP_W-1:0]         out_op;
    logic [DATA_W-1:0]       out_val1, out_val2, out_imm, out_pc;
    logic [ROB_W-1:0]        out_rob;
    logic [$clog2(DEPTH):0]  count;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    rs_age_station #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rob(in_rob),
        .in_val1(in_val1), .in_val2(in_val2), .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_imm(in_imm), .in_pc(in_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_ready(alu_ready), .flush(flush),
        .out_op(out_op), .out_val1(out_val1), .out_val2(out_val2), .out_imm(out_imm),
        .out_rob(out_rob), .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int k, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] val);
        cdb_valid[k]                 = 1'b1;
        cdb_tag[k*ROB_W +: ROB_W]    = tag;
        cdb_value[k*DATA_W +: DATA_W] = val;
    endtask

    task automatic clear_bus();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_value = '0;
    endtask

    task automatic set_in(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                          input logic [DATA_W-1:0] v1, input logic [ROB_W-1:0] t1,
                          input logic [DATA_W-1:0] v2, input logic [ROB_W-1:0] t2,
                          input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc);
        in_valid = 1'b1;
        in_op = op; in_rob = rob; in_val1 = v1; in_tag1 = t1;
        in_val2 = v2; in_tag2 = t2; in_imm = imm; in_pc = pc;
    endtask

    function automatic exp_t mk(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                                input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] imm,
                                input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] pc);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.rob = rob; e.pc = pc;
        return e;
    endfunction

    // Issue monitor: every non-zero out_op must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_op != '0) begin
            if (sb.size() == 0) begin
                check_val("spurious_issue", 64'(out_op), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("out_op",   64'(out_op),   64'(e.op));
                check_val("out_val1", 64'(out_val1), 64'(e.v1));
                check_val("out_val2", 64'(out_val2), 64'(e.v2));
                check_val("out_imm",  64'(out_imm),  64'(e.imm));
                check_val("out_rob",  64'(out_rob),  64'(e.rob));
                check_val("out_pc",   64'(out_pc),   64'(e.pc));
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; alu_ready = 1'b0; flush = 1'b0;
        in_op = '0; in_rob = '0; in_val1 = '0; in_val2 = '0; in_tag1 = '0; in_tag2 = '0;
        in_imm = '0; in_pc = '0;
        clear_bus();
        tick(2);
        rst = 1'b0;

        // Reset and idle
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val("idle_out_op", 64'(out_op), 64'd0);
            check_val("idle_count", 64'(count), 64'd0);
            check_val("idle_in_ready", 64'(in_ready), 64'd1);
        end

        // Operands already available: issue one cycle after allocate
        alu_ready = 1'b1;
        set_in(6'd3, 4'd2, 32'd5, 4'd0, 32'd7, 4'd0, 32'h10, 32'h400);
        sb.push_back(mk(6'd3, 32'd5, 32'd7, 32'h10, 4'd2, 32'h400));
        tick();
        in_valid = 1'b0;
        check_val("simple_count_alloc", 64'(count), 64'd1);
        tick();
        check_val("simple_count_after", 64'(count), 64'd0);
        tick(2);
        check_val("simple_sb_empty", 64'(sb.size()), 64'd0);

        // Wakeup on bus 1 the cycle after allocate
        set_in(6'd5, 4'd3, 32'h11, 4'd4, 32'd8, 4'd0, 32'h20, 32'h404);
        sb.push_back(mk(6'd5, 32'hAA, 32'd8, 32'h20, 4'd3, 32'h404));
        tick();
        in_valid = 1'b0;
        set_bus(1, 4'd4, 32'hAA);
        check_val("wake_not_issued_yet", 64'(out_op), 64'd0);
        tick();
        clear_bus();
        check_val("wake_count", 64'(count), 64'd1);
        tick(3);
        check_val("wake_sb_empty", 64'(sb.size()), 64'd0);

        // Same-cycle bypass on allocate
        set_in(6'd9, 4'd5, 32'd1, 4'd0, 32'h22, 4'd6, 32'h30, 32'h408);
        set_bus(2, 4'd6, 32'd9);
        sb.push_back(mk(6'd9, 32'd1, 32'd9, 32'h30, 4'd5, 32'h408));
        tick();
        in_valid = 1'b0;
        clear_bus();
        tick(3);
        check_val("bypass_sb_empty", 64'(sb.size()), 64'd0);
        check_val("bypass_count", 64'(count), 64'd0);

        // Fill all entries blocked on tag 7, then release in age order
        alu_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_in(6'(i + 1), 4'((i % 15) + 1), 32'h5555, 4'd7, 32'(i), 4'd0, 32'(100 + i), 32'(32'h1000 + i));
            sb.push_back(mk(6'(i + 1), 32'h70, 32'(i), 32'(100 + i), 4'((i % 15) + 1), 32'(32'h1000 + i)));
            tick();
        end
        check_val("full_in_ready", 64'(in_ready), 64'd0);
        check_val("full_count", 64'(count), 64'd16);
        set_in(6'd40, 4'd9, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 32'hDEAD);
        tick(2);
        in_valid = 1'b0;
        check_val("full_drop_count", 64'(count), 64'd16);
        set_bus(0, 4'd7, 32'h70);
        set_bus(1, 4'd0, 32'h99);
        set_bus(2, 4'd7, 32'h72);
        tick();
        clear_bus();
        alu_ready = 1'b1;
        for (int c = 0; c < 40 && count != '0; c++) tick();
        check_val("drain_count", 64'(count), 64'd0);
        tick(2);
        check_val("drain_sb_empty", 64'(sb.size()), 64'd0);

        // Flush with concurrent dispatch drops everything
        alu_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(6'd12, 4'd1, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 32'(32'h2000 + i));
            tick();
        end
        check_val("pre_flush_count", 64'(count), 64'd8);
        set_in(6'd13, 4'd2, 32'd1, 4'd0, 32'd2, 4'd0, 32'd0, 32'h3000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("flush_count", 64'(count), 64'd0);
        check_val("flush_out_op", 64'(out_op), 64'd0);
        alu_ready = 1'b1;
        set_bus(0, 4'd9, 32'h1);
        tick();
        clear_bus();
        tick(4);
        check_val("post_flush_count", 64'(count), 64'd0);

        // rdy=0 freezes the station, dispatch ignored while frozen
        set_in(6'd2, 4'd4, 32'd3, 4'd0, 32'd4, 4'd0, 32'h50, 32'h500);
        sb.push_back(mk(6'd2, 32'd3, 32'd4, 32'h50, 4'd4, 32'h500));
        tick();
        rdy = 1'b0;
        set_in(6'd7, 4'd6, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 32'h600);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("frozen_count", 64'(count), 64'd1);
            check_val("frozen_out_op", 64'(out_op), 64'd0);
        end
        in_valid = 1'b0;
        rdy = 1'b1;
        tick(3);
        check_val("thaw_count", 64'(count), 64'd0);
        check_val("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
